// File: rtl/decode_pkg.sv
// Shared constants for the decode stage: MIPS opcodes and instruction field positions.
// The write-through bypass is selected at build time with DECODE_BYPASS_EN.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int OP_LO  = 26;
  localparam int OP_W   = 6;
  localparam int RS_LO  = 21;
  localparam int RT_LO  = 16;
  localparam int RD_LO  = 11;
  localparam int IMM_LO = 0;
  localparam int IMM_W  = 16;

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic is_zero_ext(input logic [OP_W-1:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 2-read/1-write register file, entry 0 hardwired to zero, async active-low clear.
// With DECODE_BYPASS_EN a same-cycle write is forwarded to matching read ports.
module regfile_2r1w #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [XLEN-1:0] mem [DEPTH];
  logic            wr_live;
  logic [XLEN-1:0] stored1;
  logic [XLEN-1:0] stored2;

  assign wr_live = we && (waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_live) begin
      mem[waddr] <= wdata;
    end
  end

  assign stored1 = (raddr1 == '0) ? '0 : mem[raddr1];
  assign stored2 = (raddr2 == '0) ? '0 : mem[raddr2];

`ifdef DECODE_BYPASS_EN
  always_comb begin
    rdata1 = stored1;
    rdata2 = stored2;
    if (wr_live && (waddr == raddr1)) rdata1 = wdata;
    if (wr_live && (waddr == raddr2)) rdata2 = wdata;
  end
`else
  always_comb begin
    rdata1 = stored1;
    rdata2 = stored2;
  end
`endif

endmodule

// File: rtl/decode_stage.sv
// MIPS-style decode stage: field extraction, immediate extension, load-use hazard
// detection and the ID/EX register. DECODE_BYPASS_EN enables regfile write-through.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int IW     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [IW-1:0]     instruction,
  input  logic              stall,
  input  logic              flush,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [XLEN-1:0]   writeData,
  input  logic              ex_memread,
  input  logic [ADDR_W-1:0] ex_rt,
  output logic              hazard,
  output logic              out_valid,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2,
  output logic [ADDR_W-1:0] ins1,
  output logic [ADDR_W-1:0] ins2,
  output logic [ADDR_W-1:0] rs_out,
  output logic [IW-1:0]     insOut,
  output logic [XLEN-1:0]   signEx
);

  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic [IMM_W-1:0]  imm;
  logic [XLEN-1:0]   imm_ext;
  logic [XLEN-1:0]   rf_rd1;
  logic [XLEN-1:0]   rf_rd2;
  logic              wb_live;

  assign opcode = instruction[OP_LO +: OP_W];
  assign rs     = instruction[RS_LO +: ADDR_W];
  assign rt     = instruction[RT_LO +: ADDR_W];
  assign rd     = instruction[RD_LO +: ADDR_W];
  assign imm    = instruction[IMM_LO +: IMM_W];

  assign imm_ext = is_zero_ext(opcode) ? {{(XLEN-IMM_W){1'b0}}, imm}
                                       : {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};

  // Upstream turns this into stall (hold IF/ID) plus flush (bubble into ID/EX).
  assign hazard = in_valid && ex_memread && (ex_rt != '0) &&
                  ((ex_rt == rs) || (ex_rt == rt));

  assign wb_live = regWrite && (writeReg != '0);

  regfile_2r1w #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (regWrite),
    .waddr  (writeReg),
    .wdata  (writeData),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  // ID/EX handshake: out_valid marks a live instruction. flush squashes the
  // register to zero and beats stall; stall holds every field but refreshes a
  // held operand whose source register is written back this cycle; otherwise
  // the register loads the current decode and out_valid follows in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      rd1       <= '0;
      rd2       <= '0;
      ins1      <= '0;
      ins2      <= '0;
      rs_out    <= '0;
      insOut    <= '0;
      signEx    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      rd1       <= '0;
      rd2       <= '0;
      ins1      <= '0;
      ins2      <= '0;
      rs_out    <= '0;
      insOut    <= '0;
      signEx    <= '0;
    end else if (stall) begin
      if (wb_live && (writeReg == rs_out)) rd1 <= writeData;
      if (wb_live && (writeReg == ins1))   rd2 <= writeData;
    end else begin
      out_valid <= in_valid;
      rd1       <= rf_rd1;
      rd2       <= rf_rd2;
      ins1      <= rt;
      ins2      <= rd;
      rs_out    <= rs;
      insOut    <= instruction;
      signEx    <= imm_ext;
    end
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised successor to the single-cycle decode unit of the MIPS CPU.
- Decodes one instruction per cycle and reads two operands from an internal register file.
- Registers all results into the ID/EX pipeline register with a valid/stall/flush handshake.
- Accepts one writeback write per cycle and flags load-use hazards to the fetch stage.
- Sits between the IF/ID register and the execute stage.

Parameters:
- XLEN, 32: data width of registers, operands and the extended immediate.
- ADDR_W, 5: register-address width; the register file has 2**ADDR_W entries.
- IW, 32: instruction width; field positions follow MIPS (rs [25:21], rt [20:16], rd [15:11], imm [15:0]).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  the instruction input is valid.
- instruction  in  IW  instruction from IF/ID.
- stall  in  1  hold the ID/EX register.
- flush  in  1  squash the ID/EX register.
- regWrite  in  1  writeback enable.
- writeReg  in  ADDR_W  writeback address.
- writeData  in  XLEN  writeback data.
- ex_memread  in  1  the instruction in EX is a load.
- ex_rt  in  ADDR_W  destination of the load in EX.
- hazard  out  1  combinational load-use stall request.
- out_valid  out  1  ID/EX register holds a live instruction.
- rd1, rd2  out  XLEN  registered operands for rs and rt.
- ins1, ins2  out  ADDR_W  registered rt and rd fields.
- rs_out  out  ADDR_W  registered rs field.
- insOut  out  IW  registered instruction.
- signEx  out  XLEN  registered extended immediate.

Behaviour:
- Reset:
  - Asserting rst_n low clears all register-file entries and all ID/EX outputs to 0 immediately, including out_valid.
  - Reset asserted mid-operation discards in-flight state; no write completes on that edge.
- Register file:
  - Entry 0 always reads 0. A write to address 0 is ignored.
  - A write occurs at the rising edge when regWrite=1.
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Edge update priority, highest first:
  1. flush=1: out_valid<=0; rd1/rd2/signEx/insOut<=0; flush wins over stall.
  2. stall=1: all fields hold. If regWrite targets the held rs_out (or the held rt) and the address is non-zero, rd1 (rd2) is replaced by writeData, so a stalled instruction never carries a stale operand.
  3. Otherwise: out_valid<=in_valid, and all fields load from the current instruction.
- Immediate extension:
  - Zero-extended for opcodes 0x0C (andi), 0x0D (ori), 0x0E (xori).
  - Sign-extended from bit 15 to XLEN for all other opcodes.
  - Opcode constants live in the package.
- hazard = in_valid & ex_memread & (ex_rt!=0) & (ex_rt==rs | ex_rt==rt).
  - hazard does not stall the block by itself. Upstream feeds it back as stall (hold IF/ID) plus flush (insert a bubble).
- in_valid=0 with no stall/flush: out_valid<=0. Other fields still load; they are don't-care.

Optional Feature:
- Macro: DECODE_BYPASS_EN.
- Defined: write-through bypass. If regWrite=1, writeReg!=0 and writeReg equals the rs (rt) being read in the same cycle, rd1 (rd2) captures writeData instead of the old entry.
- Undefined: the read returns the pre-write entry. The pipeline must then cover the writeback-to-decode distance with an extra stall.
- The stall-refresh rule in Behaviour applies in both builds.

Decomposition:
- Package decode_pkg holds:
  - opcode constants: OP_RTYPE=6'h00, OP_ANDI=6'h0C, OP_ORI=6'h0D, OP_XORI=6'h0E, OP_LW=6'h23, OP_SW=6'h2B;
  - field-position localparams.
- One sub-module, regfile_2r1w:
  - 2**ADDR_W x XLEN, two combinational read ports, one synchronous write port;
  - asynchronous active-low clear, register 0 hardwired to 0;
  - bypass under DECODE_BYPASS_EN.
- decode_stage holds field extraction, immediate extension, hazard logic and the ID/EX register.

Test Plan:
1. Reset/write/read: release rst_n. Write reg 2=35 (regWrite=1, writeReg=2, writeData=35). Next cycle issue 0x00430820 (add $1,$2,$3) -> rd1=35, rd2=0, ins1=3, ins2=1, out_valid=1.
2. Zero register: write reg 0=0xFFFF_FFFF, then read rs=0 -> rd1=0.
3. Immediates:
   - 0x2002FFFF (addi $2,$0,-1) -> signEx=0xFFFF_FFFF.
   - 0x3402FFFF (ori) -> signEx=0x0000_FFFF.
4. Same-cycle write/read of reg 5=0x1234 while decoding rs=5:
   - DECODE_BYPASS_EN defined -> rd1=0x1234.
   - DECODE_BYPASS_EN undefined -> rd1=old value.
5. Stall then flush:
   - Hold stall=1 for 3 cycles while reg 1 is written with 77 -> outputs frozen except rd1 becomes 77.
   - flush=1 together with stall=1 -> out_valid=0, rd1=0.
6. Load-use: ex_memread=1, ex_rt=2, decoding rt=2 -> hazard=1.
   - Same case with ex_rt=0 -> hazard=0.
   - Assert rst_n=0 mid-sequence -> all outputs 0 asynchronously.
